alu_muldiv: RTL and testbench

- Parametrised iterative multiply/divide unit implementing the RV32M/RV64M integer ops (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- Sits beside the single-cycle ALU in the execute stage.
- Accepts one operation at a time through a valid/ready handshake and returns one result after a fixed, data-independent latency.
- Special cases (divide-by-zero, signed overflow) complete early.

---
 rtl/alu_muldiv_if.sv | 23 ++
 rtl/alu_muldiv.sv | 138 +++++++++++++
 tb/tb_alu_muldiv.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/alu_muldiv_if.sv
// rtl/alu_muldiv_if.sv - request/result bundle between execute stage and mul/div unit
interface alu_muldiv_if #(
    parameter int XLEN = 32
);
    logic            valid_i;
    logic            ready_o;
    logic [2:0]      op_i;
    logic [XLEN-1:0] op_1_i;
    logic [XLEN-1:0] op_2_i;
    logic            abort_i;
    logic            valid_o;
    logic [XLEN-1:0] result_o;

    modport master (
        output valid_i, op_i, op_1_i, op_2_i, abort_i,
        input  ready_o, valid_o, result_o
    );

    modport slave (
        input  valid_i, op_i, op_1_i, op_2_i, abort_i,
        output ready_o, valid_o, result_o
    );
endinterface

// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - iterative RV32M/RV64M multiply/divide, fixed latency with early-out
module alu_muldiv #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic       clk_i,
    input  logic       rst_i,
    alu_muldiv_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t              state;
    logic [CNT_W-1:0]    counter;
    logic [2:0]          op_q;
    logic                neg_q;
    logic [XLEN-1:0]     opnd_q;
    logic [2*XLEN-1:0]   acc_q;
    logic                ready_q;
    logic                done_q;
    logic [XLEN-1:0]     result_q;

    logic                is_div, a_signed, b_signed, a_neg, b_neg, neg_in;
    logic [XLEN-1:0]     a_mag, b_mag, early_res;
    logic                div_zero, div_ovf;

    always_comb begin
        is_div   = bus.op_i[2];
        a_signed = is_div ? ~bus.op_i[0] : (bus.op_i[1:0] == 2'd1 || bus.op_i[1:0] == 2'd2);
        b_signed = is_div ? ~bus.op_i[0] : (bus.op_i[1:0] == 2'd1);
        a_neg    = a_signed & bus.op_1_i[XLEN-1];
        b_neg    = b_signed & bus.op_2_i[XLEN-1];
        a_mag    = a_neg ? ({XLEN{1'b0}} - bus.op_1_i) : bus.op_1_i;
        b_mag    = b_neg ? ({XLEN{1'b0}} - bus.op_2_i) : bus.op_2_i;
        // Remainder takes the dividend's sign; quotient and products take the XOR.
        neg_in   = (bus.op_i[2] & bus.op_i[1]) ? a_neg : (a_neg ^ b_neg);
        div_zero = is_div & (bus.op_2_i == {XLEN{1'b0}});
        div_ovf  = is_div & ~bus.op_i[0]
                 & (bus.op_1_i == {1'b1, {(XLEN-1){1'b0}}})
                 & (bus.op_2_i == {XLEN{1'b1}});
        if (div_zero)
            early_res = bus.op_i[1] ? bus.op_1_i : {XLEN{1'b1}};
        else
            early_res = bus.op_i[1] ? {XLEN{1'b0}} : bus.op_1_i;
    end

    logic [XLEN:0]       mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0]   mul_nxt, div_nxt, acc_nxt, prod_fin;
    logic [XLEN-1:0]     quo, rem, fin_res;

    always_comb begin
        // Multiply: acc = {partial_hi, multiplier}, add multiplicand on LSB then shift right.
        mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
        mul_nxt = {mul_sum, acc_q[XLEN-1:1]};

        // Divide: acc = {remainder, dividend/quotient}, shift left and trial-subtract.
        div_shift = acc_q[2*XLEN-1:XLEN-1];
        div_diff  = div_shift - {1'b0, opnd_q};
        if (div_diff[XLEN])
            div_nxt = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        else
            div_nxt = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

        acc_nxt  = op_q[2] ? div_nxt : mul_nxt;
        prod_fin = neg_q ? ({(2*XLEN){1'b0}} - acc_nxt) : acc_nxt;
        quo      = acc_nxt[XLEN-1:0];
        rem      = acc_nxt[2*XLEN-1:XLEN];

        if (!op_q[2])
            fin_res = (op_q[1:0] == 2'd0) ? prod_fin[XLEN-1:0] : prod_fin[2*XLEN-1:XLEN];
        else if (op_q[1])
            fin_res = neg_q ? ({XLEN{1'b0}} - rem) : rem;
        else
            fin_res = neg_q ? ({XLEN{1'b0}} - quo) : quo;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= S_IDLE;
            counter  <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.valid_i && !bus.abort_i) begin
                        op_q    <= bus.op_i;
                        neg_q   <= neg_in;
                        opnd_q  <= is_div ? b_mag : a_mag;
                        acc_q   <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
                        ready_q <= 1'b0;
                        if (div_zero || div_ovf) begin
                            state    <= S_DONE;
                            done_q   <= 1'b1;
                            result_q <= early_res;
                        end else begin
                            state   <= S_CALC;
                            counter <= CNT_W'(XLEN - 1);
                        end
                    end
                end
                S_CALC: begin
                    if (bus.abort_i) begin
                        state   <= S_IDLE;
                        ready_q <= 1'b1;
                    end else begin
                        acc_q   <= acc_nxt;
                        counter <= counter - 1'b1;
                        if (counter == '0) begin
                            state    <= S_DONE;
                            done_q   <= 1'b1;
                            result_q <= fin_res;
                        end
                    end
                end
                S_DONE: begin
                    state   <= S_IDLE;
                    ready_q <= 1'b1;
                    done_q  <= 1'b0;
                end
                default: begin
                    state   <= S_IDLE;
                    ready_q <= 1'b1;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // A flush landing on the result cycle must suppress the pulse immediately.
    assign bus.ready_o  = ready_q;
    assign bus.valid_o  = done_q & ~bus.abort_i;
    assign bus.result_o = result_q;
endmodule

// File: tb/tb_alu_muldiv.sv
// tb/tb_alu_muldiv.sv - randomized and directed checking of alu_muldiv against an arithmetic model
module tb_alu_muldiv;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    logic [31:0] last_exp = '0;

    alu_muldiv_if #(.XLEN(32)) bus ();

    alu_muldiv #(.XLEN(32), .CNT_W(6)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint          ub_s = longint'({32'h0, b});
        longint unsigned ua = {32'h0, a};
        longint unsigned ub = {32'h0, b};
        longint unsigned pu;
        longint          ps;
        logic            ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin pu = ua * ub;   return pu[31:0];  end
            3'd1: begin ps = sa * sb;   return ps[63:32]; end
            3'd2: begin ps = sa * ub_s; return ps[63:32]; end
            3'd3: begin pu = ua * ub;   return pu[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                ps = sa / sb; return ps[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                ps = sa % sb; return ps[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && b == 0) return 1;
        if (op[2] && !op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    task automatic wait_ready();
        int w = 0;
        while (!bus.ready_o && w < 100) begin @(negedge clk); w++; end
    endtask

    task automatic exec_check(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int   lat;
        logic busy_bad = 1'b0;
        logic [31:0] exp = ref_model(op, a, b);
        wait_ready();
        bus.valid_i = 1'b1;
        bus.op_i    = op;
        bus.op_1_i  = a;
        bus.op_2_i  = b;
        @(negedge clk);
        bus.valid_i = 1'b0;
        bus.op_i    = 3'($urandom);
        bus.op_1_i  = $urandom;
        bus.op_2_i  = $urandom;
        lat = 1;
        while (!bus.valid_o && lat < 100) begin
            if (bus.ready_o) busy_bad = 1'b1;
            @(negedge clk);
            lat++;
        end
        if (bus.ready_o) busy_bad = 1'b1;
        check_eq({tag, "_res"}, bus.result_o, exp);
        check_eq({tag, "_lat"}, lat, ref_latency(op, a, b));
        check_eq({tag, "_busy"}, busy_bad, 1'b0);
        last_exp = exp;
        @(negedge clk);
    endtask

    initial begin
        bus.valid_i = 1'b0;
        bus.op_i    = '0;
        bus.op_1_i  = '0;
        bus.op_2_i  = '0;
        bus.abort_i = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_ready", bus.ready_o, 1'b1);
        check_eq("rst_valid", bus.valid_o, 1'b0);
        check_eq("rst_result", bus.result_o, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        exec_check("mul_neg",   3'd0, 32'h0000_0007, 32'hFFFF_FFFD);
        exec_check("mulh_min",  3'd1, 32'h8000_0000, 32'h8000_0000);
        exec_check("mulhu_min", 3'd3, 32'h8000_0000, 32'h8000_0000);
        exec_check("mulhsu_m1", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        exec_check("div_m7_2",  3'd4, 32'hFFFF_FFF9, 32'd2);
        exec_check("rem_m7_2",  3'd6, 32'hFFFF_FFF9, 32'd2);
        exec_check("divu_100",  3'd5, 32'd100, 32'd7);
        exec_check("remu_100",  3'd7, 32'd100, 32'd7);
        exec_check("divu_z",    3'd5, 32'd5, 32'd0);
        exec_check("rem_z",     3'd6, 32'd5, 32'd0);
        exec_check("div_ovf",   3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        exec_check("rem_ovf",   3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

        // Abort while idle must block the accept.
        wait_ready();
        bus.valid_i = 1'b1; bus.abort_i = 1'b1; bus.op_i = 3'd0;
        bus.op_1_i = 32'd9; bus.op_2_i = 32'd9;
        @(negedge clk);
        bus.valid_i = 1'b0; bus.abort_i = 1'b0;
        check_eq("idle_abort_ready", bus.ready_o, 1'b1);
        check_eq("idle_abort_valid", bus.valid_o, 1'b0);

        // Abort in CALC cycle 10.
        begin
            logic seen = 1'b0;
            bus.valid_i = 1'b1; bus.op_i = 3'd4;
            bus.op_1_i = 32'd1000; bus.op_2_i = 32'd3;
            @(negedge clk);
            bus.valid_i = 1'b0;
            for (int i = 1; i < 10; i++) begin
                if (bus.valid_o) seen = 1'b1;
                @(negedge clk);
            end
            bus.abort_i = 1'b1;
            if (bus.valid_o) seen = 1'b1;
            @(negedge clk);
            bus.abort_i = 1'b0;
            check_eq("abort_no_valid", seen | bus.valid_o, 1'b0);
            check_eq("abort_ready", bus.ready_o, 1'b1);
            check_eq("abort_result_held", bus.result_o, last_exp);
        end
        exec_check("mul_after_abort", 3'd0, 32'd3, 32'd4);

        // Reset mid-CALC with valid held high.
        bus.valid_i = 1'b1; bus.op_i = 3'd1;
        bus.op_1_i = $urandom; bus.op_2_i = $urandom;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_ready", bus.ready_o, 1'b1);
        check_eq("mid_rst_valid", bus.valid_o, 1'b0);
        check_eq("mid_rst_result", bus.result_o, 32'h0);
        @(negedge clk);
        check_eq("rst_hold_ready", bus.ready_o, 1'b1);
        bus.valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_ready", bus.ready_o, 1'b1);
        check_eq("post_rst_valid", bus.valid_o, 1'b0);

        for (int n = 0; n < 200; n++) begin
            logic [2:0]  op = 3'($urandom_range(0, 7));
            logic [31:0] a  = $urandom;
            logic [31:0] b  = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'h0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
                3: b = 32'($signed(-$urandom_range(1, 20)));
                default: ;
            endcase
            exec_check("rand", op, a, b);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
